hazard_controller: RTL and testbench

Central pipeline sequencer for the RV32E core. It drives per-stage stall (hold) and flush (bubble-insert) controls for the IF, ID, EX, MEMPREP, MEMEX and WB stage registers, in the following cases:
- load-use hazards
- taken-branch redirects
- multi-cycle data-memory waits
- post-reset pipeline clearing

Flush outputs feed the `invalid_*` inputs of the stage registers, which zero `regfile_we` for the bubble.

---
 rtl/core_pkg.sv | 21 ++
 rtl/load_use_detect.sv | 35 +++
 rtl/hazard_controller.sv | 212 +++++++++++++++++++++
 tb/tb_hazard_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32E core pipeline control.
//   hazard_state_t : hazard_controller FSM states (INIT, RUN, MEM_WAIT)
//   RD_SEL_*       : writeback source select encodings (RD_SEL_MEM = load)
//   *_DEFAULT      : default hazard_controller parameter values
package core_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_t;

  localparam logic [1:0] RD_SEL_ALU = 2'd0;
  localparam logic [1:0] RD_SEL_MEM = 2'd1;
  localparam logic [1:0] RD_SEL_PC4 = 2'd2;
  localparam logic [1:0] RD_SEL_IMM = 2'd3;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;
  localparam int unsigned INIT_CYCLES_DEFAULT = 5;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags when a used decode source register
// matches the destination of one producer stage holding a load (writes back,
// data from memory, rd != x0).
// Ports:
//   rs1, rs2            in  decode source registers
//   rs1_used, rs2_used  in  decode instruction really reads the source
//   rd                  in  producer destination register
//   regfile_we          in  producer will write back
//   rd_data_sel         in  producer writeback source
//   hazard              out load-use hazard against this producer
module load_use_detect
  import core_pkg::*;
(
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [3:0] rd,
  input  logic       regfile_we,
  input  logic [1:0] rd_data_sel,
  output logic       hazard
);

  logic producer_is_load;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    producer_is_load = regfile_we && (rd_data_sel == RD_SEL_MEM) && (rd != 4'd0);
    rs1_hit          = rs1_used && (rs1 == rd);
    rs2_hit          = rs2_used && (rs2 == rd);
    hazard           = producer_is_load && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_controller.sv
// Central pipeline sequencer for the RV32E core. Produces per-stage stall
// (hold) and flush (bubble) controls for load-use hazards, taken-branch
// redirects, data-memory waits (with timeout abort) and post-reset clearing.
// Optional feature macro: HAZARD_PERF_COUNTERS_EN adds stall_count/flush_count.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   rs1_ID, rs2_ID, rs*_used_ID     decode sources and their use flags
//   rd_*, regfile_we_*, rd_data_sel_*  EX / MEMPREP producer info
//   branch_taken_EX                 EX resolved a taken branch/jump
//   mem_req_MEMEX, mem_ready        MEMEX access request / completion
//   stall_*                         hold IF(PC), ID, EX, MEMPREP, MEMEX
//   flush_*                         bubble into ID, EX, MEMPREP, MEMEX, WB
//   pc_redirect_en                  PC loads branch target
//   mem_timeout                     sticky memory timeout flag
//   stall_count, flush_count        (HAZARD_PERF_COUNTERS_EN only)
module hazard_controller
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rs1_ID,
  input  logic [3:0]  rs2_ID,
  input  logic        rs1_used_ID,
  input  logic        rs2_used_ID,
  input  logic [3:0]  rd_EX,
  input  logic [3:0]  rd_MEMPREP,
  input  logic        regfile_we_EX,
  input  logic        regfile_we_MEMPREP,
  input  logic [1:0]  rd_data_sel_EX,
  input  logic [1:0]  rd_data_sel_MEMPREP,
  input  logic        branch_taken_EX,
  input  logic        mem_req_MEMEX,
  input  logic        mem_ready,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        stall_EX,
  output logic        stall_MEMPREP,
  output logic        stall_MEMEX,
  output logic        flush_ID,
  output logic        flush_EX,
  output logic        flush_MEMPREP,
  output logic        flush_MEMEX,
  output logic        flush_WB,
  output logic        pc_redirect_en,
  output logic        mem_timeout
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LIMIT   = TW'(MEM_TIMEOUT);
  localparam logic [IW-1:0] INIT_START = IW'(INIT_CYCLES - 1);

  hazard_state_t state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          mem_timeout_q;
  logic          timeout_set;
  logic          run_eval;
  logic          hazard_ex;
  logic          hazard_mp;

  load_use_detect u_lud_ex (
    .rs1         (rs1_ID),
    .rs2         (rs2_ID),
    .rs1_used    (rs1_used_ID),
    .rs2_used    (rs2_used_ID),
    .rd          (rd_EX),
    .regfile_we  (regfile_we_EX),
    .rd_data_sel (rd_data_sel_EX),
    .hazard      (hazard_ex)
  );

  load_use_detect u_lud_mp (
    .rs1         (rs1_ID),
    .rs2         (rs2_ID),
    .rs1_used    (rs1_used_ID),
    .rs2_used    (rs2_used_ID),
    .rd          (rd_MEMPREP),
    .regfile_we  (regfile_we_MEMPREP),
    .rd_data_sel (rd_data_sel_MEMPREP),
    .hazard      (hazard_mp)
  );

  always_comb begin
    stall_IF       = 1'b0;
    stall_ID       = 1'b0;
    stall_EX       = 1'b0;
    stall_MEMPREP  = 1'b0;
    stall_MEMEX    = 1'b0;
    flush_ID       = 1'b0;
    flush_EX       = 1'b0;
    flush_MEMPREP  = 1'b0;
    flush_MEMEX    = 1'b0;
    flush_WB       = 1'b0;
    pc_redirect_en = 1'b0;
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    to_cnt_d       = to_cnt_q;
    timeout_set    = 1'b0;
    run_eval       = 1'b0;

    case (state_q)
      INIT: begin
        flush_ID      = 1'b1;
        flush_EX      = 1'b1;
        flush_MEMPREP = 1'b1;
        flush_MEMEX   = 1'b1;
        flush_WB      = 1'b1;
        if (init_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          init_cnt_d = init_cnt_q - IW'(1);
        end
      end
      RUN: run_eval = 1'b1;
      MEM_WAIT: begin
        if (mem_ready) begin
          // Exit is combinational: this cycle is already judged as RUN, so
          // a branch held in the frozen EX redirects right now.
          run_eval = 1'b1;
          state_d  = RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LIMIT) begin
          // Abort: drop the MEMEX access while upstream stays frozen.
          stall_IF      = 1'b1;
          stall_ID      = 1'b1;
          stall_EX      = 1'b1;
          stall_MEMPREP = 1'b1;
          flush_MEMEX   = 1'b1;
          flush_WB      = 1'b1;
          timeout_set   = 1'b1;
          state_d       = RUN;
          to_cnt_d      = '0;
        end else begin
          stall_IF      = 1'b1;
          stall_ID      = 1'b1;
          stall_EX      = 1'b1;
          stall_MEMPREP = 1'b1;
          stall_MEMEX   = 1'b1;
          flush_WB      = 1'b1;
          to_cnt_d      = to_cnt_q + TW'(1);
        end
      end
      default: state_d = INIT;
    endcase

    if (run_eval) begin
      if (mem_req_MEMEX && !mem_ready) begin
        stall_IF      = 1'b1;
        stall_ID      = 1'b1;
        stall_EX      = 1'b1;
        stall_MEMPREP = 1'b1;
        stall_MEMEX   = 1'b1;
        flush_WB      = 1'b1;
        state_d       = MEM_WAIT;
        to_cnt_d      = TW'(1);
      end else if (branch_taken_EX) begin
        // The decode instruction is squashed, so its load-use is moot.
        pc_redirect_en = 1'b1;
        flush_ID       = 1'b1;
        flush_EX       = 1'b1;
      end else if (hazard_ex || hazard_mp) begin
        stall_IF = 1'b1;
        stall_ID = 1'b1;
        flush_EX = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_cnt_q    <= INIT_START;
      to_cnt_q      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      to_cnt_q   <= to_cnt_d;
      if (timeout_set) begin
        mem_timeout_q <= 1'b1;
      end
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_ID) begin
        stall_count <= stall_count + 32'd1;
      end
      if (pc_redirect_en) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller. Control outputs are packed as
// {stall_IF,ID,EX,MEMPREP,MEMEX, flush_ID,EX,MEMPREP,MEMEX,WB, redirect, timeout}.
module tb_hazard_controller;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rs1_ID, rs2_ID, rd_EX, rd_MEMPREP;
  logic       rs1_used_ID, rs2_used_ID;
  logic       regfile_we_EX, regfile_we_MEMPREP;
  logic [1:0] rd_data_sel_EX, rd_data_sel_MEMPREP;
  logic       branch_taken_EX, mem_req_MEMEX, mem_ready;
  logic       stall_IF, stall_ID, stall_EX, stall_MEMPREP, stall_MEMEX;
  logic       flush_ID, flush_EX, flush_MEMPREP, flush_MEMEX, flush_WB;
  logic       pc_redirect_en, mem_timeout;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_count, flush_count;
`endif
  logic [11:0] ctl;

  localparam logic [11:0] V_IDLE  = 12'b00000_00000_0_0;
  localparam logic [11:0] V_ALLF  = 12'b00000_11111_0_0;
  localparam logic [11:0] V_MEMW  = 12'b11111_00001_0_0;
  localparam logic [11:0] V_REDIR = 12'b00000_11000_1_0;
  localparam logic [11:0] V_LU    = 12'b11000_01000_0_0;
  localparam logic [11:0] V_TOUT  = 12'b11110_00011_0_0;
  localparam logic [11:0] V_TFLAG = 12'b00000_00000_0_1;

  int unsigned vec_cnt  = 0;
  int unsigned miss_cnt = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(64), .INIT_CYCLES(5)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rs1_ID              (rs1_ID),
    .rs2_ID              (rs2_ID),
    .rs1_used_ID         (rs1_used_ID),
    .rs2_used_ID         (rs2_used_ID),
    .rd_EX               (rd_EX),
    .rd_MEMPREP          (rd_MEMPREP),
    .regfile_we_EX       (regfile_we_EX),
    .regfile_we_MEMPREP  (regfile_we_MEMPREP),
    .rd_data_sel_EX      (rd_data_sel_EX),
    .rd_data_sel_MEMPREP (rd_data_sel_MEMPREP),
    .branch_taken_EX     (branch_taken_EX),
    .mem_req_MEMEX       (mem_req_MEMEX),
    .mem_ready           (mem_ready),
    .stall_IF            (stall_IF),
    .stall_ID            (stall_ID),
    .stall_EX            (stall_EX),
    .stall_MEMPREP       (stall_MEMPREP),
    .stall_MEMEX         (stall_MEMEX),
    .flush_ID            (flush_ID),
    .flush_EX            (flush_EX),
    .flush_MEMPREP       (flush_MEMPREP),
    .flush_MEMEX         (flush_MEMEX),
    .flush_WB            (flush_WB),
    .pc_redirect_en      (pc_redirect_en),
    .mem_timeout         (mem_timeout)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .stall_count         (stall_count),
    .flush_count         (flush_count)
`endif
  );

  assign ctl = {stall_IF, stall_ID, stall_EX, stall_MEMPREP, stall_MEMEX,
                flush_ID, flush_EX, flush_MEMPREP, flush_MEMEX, flush_WB,
                pc_redirect_en, mem_timeout};

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1_ID = '0; rs2_ID = '0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
    rd_EX = '0; rd_MEMPREP = '0;
    regfile_we_EX = 1'b0; regfile_we_MEMPREP = 1'b0;
    rd_data_sel_EX = RD_SEL_ALU; rd_data_sel_MEMPREP = RD_SEL_ALU;
    branch_taken_EX = 1'b0; mem_req_MEMEX = 1'b0; mem_ready = 1'b0;
  endtask

  // Inputs are set just after a rising edge; outputs checked at the falling edge.
  task automatic step(input string tag, input logic [11:0] exp);
    @(negedge clk);
    check_vec(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    step("reset", V_ALLF);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("init_flush", V_ALLF);
    step("init_done", V_IDLE);

    // lw x5 in EX, ID reads x5: two stall cycles as the load moves on
    rd_EX = 4'd5; regfile_we_EX = 1'b1; rd_data_sel_EX = RD_SEL_MEM;
    rs1_ID = 4'd5; rs1_used_ID = 1'b1;
    step("lu_ex", V_LU);
    rd_EX = '0; regfile_we_EX = 1'b0; rd_data_sel_EX = RD_SEL_ALU;
    rd_MEMPREP = 4'd5; regfile_we_MEMPREP = 1'b1; rd_data_sel_MEMPREP = RD_SEL_MEM;
    step("lu_mp", V_LU);

    // redirect with a concurrent load-use match
    clear_inputs();
    rd_EX = 4'd5; regfile_we_EX = 1'b1; rd_data_sel_EX = RD_SEL_MEM;
    rs1_ID = 4'd5; rs1_used_ID = 1'b1; branch_taken_EX = 1'b1;
    step("redir_lu", V_REDIR);
    clear_inputs();
    step("redir_end", V_IDLE);
`ifdef HAZARD_PERF_COUNTERS_EN
    check_vec("stall_count", stall_count, 32'd2);
    check_vec("flush_count", flush_count, 32'd1);
`endif

    // non-hazards: x0 destination, unused source, ALU producer
    rd_EX = 4'd0; regfile_we_EX = 1'b1; rd_data_sel_EX = RD_SEL_MEM;
    rs1_ID = 4'd0; rs1_used_ID = 1'b1;
    step("lu_x0", V_IDLE);
    rd_EX = 4'd7; rs1_ID = 4'd7; rs1_used_ID = 1'b0;
    step("lu_unused", V_IDLE);
    rs1_used_ID = 1'b1; rd_data_sel_EX = RD_SEL_ALU;
    step("lu_alu", V_IDLE);
    clear_inputs();
    rd_MEMPREP = 4'd9; regfile_we_MEMPREP = 1'b1; rd_data_sel_MEMPREP = RD_SEL_MEM;
    rs2_ID = 4'd9; rs2_used_ID = 1'b1;
    step("lu_mp_rs2", V_LU);

    // 3-cycle memory wait with a branch held in EX
    clear_inputs();
    mem_req_MEMEX = 1'b1; branch_taken_EX = 1'b1;
    for (int i = 0; i < 3; i++) step("memwait", V_MEMW);
    mem_ready = 1'b1;
    step("memwait_exit", V_REDIR);
    clear_inputs();
    step("after_wait", V_IDLE);

    // ready in the same cycle as the request: no stall
    mem_req_MEMEX = 1'b1; mem_ready = 1'b1;
    step("mem_zero", V_IDLE);

    // timeout: one RUN cycle plus 63 MEM_WAIT stall cycles, then the abort
    clear_inputs();
    mem_req_MEMEX = 1'b1;
    step("to_enter", V_MEMW);
    for (int i = 1; i < 64; i++) step("to_wait", V_MEMW);
    step("to_abort", V_TOUT);
    mem_req_MEMEX = 1'b0;
    step("to_flag", V_TFLAG);
    branch_taken_EX = 1'b1;
    step("to_run", V_REDIR | V_TFLAG);
    clear_inputs();

    // reset clears the sticky flag
    rst_n = 1'b0;
    step("rst_clear", V_ALLF);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
